comb_mc: RTL and testbench

Multi-channel, time-interleaved comb stage for the CIC decimator chain, with per-channel differential delay CIC_M.
- Computes y[n] = x[n] - x[n-CIC_M] independently for NUM_CH channels arriving interleaved on one sample bus.
- Adds a valid/ready handshake with backpressure, channel tagging, frame-sync checking and output bit pruning.
- Sits after the decimator's rate change; instances chain directly, out to inp.

---
 rtl/cic_pkg.sv | 39 +++
 rtl/comb_hist.sv | 45 ++++
 rtl/comb_mc.sv | 100 ++++++++++
 tb/tb_comb_mc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// cic_pkg: shared types and helpers for the CIC comb stage.
//   chan_w(n)            channel-index width, max(1, clog2(n))
//   prune(diff, sw, ow)  top ow bits of an sw-bit difference, right-aligned
//   comb_beat_t          output beat {data, chan, last}, sized for the widest use
// Optional build macro: COMB_MC_ROUND_EN selects round-half-up pruning instead
// of truncation (only has an effect when ow < sw).
// Widths handled here: sample width up to 63 bits, channel index up to 16 bits.
package cic_pkg;

  localparam int BEAT_DATA_MAX = 64;
  localparam int BEAT_CHAN_MAX = 16;

  typedef struct packed {
    logic [BEAT_DATA_MAX-1:0] data;
    logic [BEAT_CHAN_MAX-1:0] chan;
    logic                     last;
  } comb_beat_t;

  function automatic int chan_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // diff holds an sw-bit value zero-extended; result is the pruned ow-bit
  // field, zero-extended. Bits above sw after the rounding add are the
  // modulo-2^sw carry and fall away in the final mask.
  function automatic logic [BEAT_DATA_MAX-1:0] prune(
    input logic [BEAT_DATA_MAX-1:0] diff,
    input int                       sw,
    input int                       ow
  );
    logic [BEAT_DATA_MAX-1:0] d;
    d = diff;
`ifdef COMB_MC_ROUND_EN
    if (ow < sw) d = d + (64'd1 << (sw - ow - 1));
`endif
    return (d >> (sw - ow)) & ((64'd1 << ow) - 64'd1);
  endfunction

endpackage

// File: rtl/comb_hist.sv
// comb_hist: per-channel DEPTH-deep sample history for the comb stage.
//   clk   clock
//   zero  synchronous clear of every entry
//   push  shift din into channel ch's line
//   ch    channel selected for push and for dout
//   din   sample to push
//   dout  oldest entry of channel ch (the x[n-DEPTH] tap)
// Kept as its own block so a RAM-backed version can drop in later.
module comb_hist #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 1,
  parameter int W      = 16,
  parameter int CHW    = 2
) (
  input  logic           clk,
  input  logic           zero,
  input  logic           push,
  input  logic [CHW-1:0] ch,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   dout
);

  logic [NUM_CH-1:0][DEPTH-1:0][W-1:0] hist;

  always_ff @(posedge clk) begin
    if (zero) begin
      hist <= '0;
    end else if (push) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch == CHW'(c)) begin
          hist[c][0] <= din;
          for (int k = 1; k < DEPTH; k++) hist[c][k] <= hist[c][k-1];
        end
      end
    end
  end

  // Compare-based select keeps the read in range for any NUM_CH.
  always_comb begin
    dout = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch == CHW'(c)) dout = hist[c][DEPTH-1];
  end

endmodule

// File: rtl/comb_mc.sv
// comb_mc: multi-channel time-interleaved CIC comb, y[n] = x[n] - x[n-CIC_M]
// per channel, with valid/ready flow control and one output register.
//   clk, reset (sync, active high), clear (sync flush, same effect as reset)
//   samp_inp_data/valid/first/ready   interleaved input; first marks channel 0
//   samp_out_data/chan/last/valid/ready  pruned output beat with channel tag
//   sync_err  one-cycle pulse after a 'first' arrives on a nonzero channel
// Optional build macro: COMB_MC_ROUND_EN (round-half-up output pruning).
module comb_mc
  import cic_pkg::*;
#(
  parameter int SAMP_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int CIC_M      = 1,
  parameter int NUM_CH     = 4,
  localparam int CHW       = chan_w(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [SAMP_WIDTH-1:0] samp_inp_data,
  input  logic                  samp_inp_valid,
  input  logic                  samp_inp_first,
  output logic                  samp_inp_ready,
  output logic [OUT_WIDTH-1:0]  samp_out_data,
  output logic [CHW-1:0]        samp_out_chan,
  output logic                  samp_out_last,
  output logic                  samp_out_valid,
  input  logic                  samp_out_ready,
  output logic                  sync_err
);

  logic                  flush, accept, sync_bad, ch_last;
  logic [CHW-1:0]        ch, ch_eff, ch_nxt;
  logic [SAMP_WIDTH-1:0] hist_tail, diff;
  comb_beat_t            beat_d, beat_q;
  logic                  out_vld_q;
  logic                  unused_beat;

  assign flush          = reset | clear;
  assign samp_inp_ready = !out_vld_q || samp_out_ready;
  // A sample presented during a flush is dropped, not stored.
  assign accept         = samp_inp_valid && samp_inp_ready && !flush;

  // Misaligned frame start: re-sync to channel 0 and flag it.
  assign sync_bad = (NUM_CH > 1) && samp_inp_first && (ch != '0);
  assign ch_eff   = sync_bad ? '0 : ch;
  assign ch_last  = (ch_eff == CHW'(NUM_CH - 1));
  assign ch_nxt   = ch_last ? '0 : ch_eff + 1'b1;

  comb_hist #(
    .NUM_CH (NUM_CH),
    .DEPTH  (CIC_M),
    .W      (SAMP_WIDTH),
    .CHW    (CHW)
  ) u_hist (
    .clk  (clk),
    .zero (flush),
    .push (accept),
    .ch   (ch_eff),
    .din  (samp_inp_data),
    .dout (hist_tail)
  );

  // Wrapping subtract; CIC integrator growth relies on modular arithmetic.
  assign diff = samp_inp_data - hist_tail;

  always_comb begin
    beat_d      = '0;
    beat_d.data = prune(BEAT_DATA_MAX'(diff), SAMP_WIDTH, OUT_WIDTH);
    beat_d.chan = BEAT_CHAN_MAX'(ch_eff);
    beat_d.last = ch_last;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      ch        <= '0;
      out_vld_q <= 1'b0;
      beat_q    <= '0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= accept && sync_bad;
      if (accept) begin
        ch        <= ch_nxt;
        out_vld_q <= 1'b1;
        beat_q    <= beat_d;
      end else if (samp_out_ready) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign samp_out_valid = out_vld_q;
  assign samp_out_data  = beat_q.data[OUT_WIDTH-1:0];
  assign samp_out_chan  = beat_q.chan[CHW-1:0];
  assign samp_out_last  = beat_q.last;

  // Beat fields are sized for the widest configuration; high bits stay zero.
  assign unused_beat = ^{beat_q.data, beat_q.chan};

endmodule

// File: tb/tb_comb_mc.sv
// Bench for comb_mc: one model-checked instance (4 ch, M=2) plus small
// instances for hand-computed vectors (2ch/M1, 1ch/M2, 8-bit wrap, 8->4 prune).
module tb_comb_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  logic rst = 1'b1;

  // ---------------- main instance: NUM_CH=4, CIC_M=2, 16 bit ----------------
  localparam int NC0 = 4, M0 = 2;
  logic        clr0 = 0, vin0 = 0, first0 = 0, ordy0 = 1;
  logic [15:0] din0 = '0;
  logic        rdy0, ov0, last0, serr0;
  logic [15:0] od0;
  logic [1:0]  oc0;

  comb_mc #(.SAMP_WIDTH(16), .OUT_WIDTH(16), .CIC_M(M0), .NUM_CH(NC0)) d0 (
    .clk(clk), .reset(rst), .clear(clr0), .samp_inp_data(din0),
    .samp_inp_valid(vin0), .samp_inp_first(first0), .samp_inp_ready(rdy0),
    .samp_out_data(od0), .samp_out_chan(oc0), .samp_out_last(last0),
    .samp_out_valid(ov0), .samp_out_ready(ordy0), .sync_err(serr0));

  // Model: per-channel list of every accepted sample since the last flush;
  // output is x[n] - x[n-M] from that list (0 when no such sample yet).
  logic [15:0] hq[NC0][$];
  int          mch = 0;
  logic        ev = 0, el = 0, es = 0;
  logic [15:0] ed = '0;
  int          ec = 0;

  always @(posedge clk) begin
    if (rst || clr0) begin
      for (int i = 0; i < NC0; i++) hq[i].delete();
      mch = 0; ev = 0; ed = '0; ec = 0; el = 0; es = 0;
    end else begin
      es = 0;
      if (vin0 && (!ev || ordy0)) begin
        int c, n;
        logic [15:0] prev;
        c = mch;
        if (first0 && mch != 0) begin c = 0; es = 1; end
        hq[c].push_back(din0);
        n = hq[c].size();
        prev = (n > M0) ? hq[c][n-1-M0] : 16'd0;
        ed = din0 - prev;
        ec = c; el = (c == NC0-1); ev = 1;
        mch = (c + 1) % NC0;
      end else if (ordy0) begin
        ev = 0;
      end
    end
  end

  int stall_cnt = 0, out_hs = 0;
  always @(negedge clk) begin
    chk("d0_valid", ov0, ev);
    chk("d0_sync_err", serr0, es);
    chk("d0_inp_ready", rdy0, !ev || ordy0);
    if (ev) begin
      chk("d0_data", $signed(od0), $signed(ed));
      chk("d0_chan", oc0, ec);
      chk("d0_last", last0, el);
    end
    if (vin0 && !rdy0) stall_cnt++;
    if (ov0 && ordy0) out_hs++;
  end

  // Called and returns at posedge+2; holds the sample until accepted.
  task automatic send0(input logic [15:0] d, input logic f);
    bit ok;
    ok = 0;
    vin0 = 1; din0 = d; first0 = f;
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = rdy0;
      @(posedge clk); #2;
    end
    vin0 = 0; first0 = 0;
    if (!ok) chk("d0_send_timeout", 0, 1);
  endtask

  // ---------------- literal-vector instances ----------------
  logic        v1 = 0, f1 = 0, r1, ov1, l1, s1;
  logic [15:0] i1 = '0, o1;
  logic        c1;
  comb_mc #(.SAMP_WIDTH(16), .OUT_WIDTH(16), .CIC_M(1), .NUM_CH(2)) d1 (
    .clk(clk), .reset(rst), .clear(1'b0), .samp_inp_data(i1),
    .samp_inp_valid(v1), .samp_inp_first(f1), .samp_inp_ready(r1),
    .samp_out_data(o1), .samp_out_chan(c1), .samp_out_last(l1),
    .samp_out_valid(ov1), .samp_out_ready(1'b1), .sync_err(s1));

  logic        v2 = 0, r2, ov2, l2, s2;
  logic [15:0] i2 = '0, o2;
  logic        c2;
  comb_mc #(.SAMP_WIDTH(16), .OUT_WIDTH(16), .CIC_M(2), .NUM_CH(1)) d2 (
    .clk(clk), .reset(rst), .clear(1'b0), .samp_inp_data(i2),
    .samp_inp_valid(v2), .samp_inp_first(1'b0), .samp_inp_ready(r2),
    .samp_out_data(o2), .samp_out_chan(c2), .samp_out_last(l2),
    .samp_out_valid(ov2), .samp_out_ready(1'b1), .sync_err(s2));

  logic       v3 = 0, r3, ov3, l3, s3;
  logic [7:0] i3 = '0, o3;
  logic       c3;
  comb_mc #(.SAMP_WIDTH(8), .OUT_WIDTH(8), .CIC_M(1), .NUM_CH(1)) d3 (
    .clk(clk), .reset(rst), .clear(1'b0), .samp_inp_data(i3),
    .samp_inp_valid(v3), .samp_inp_first(1'b0), .samp_inp_ready(r3),
    .samp_out_data(o3), .samp_out_chan(c3), .samp_out_last(l3),
    .samp_out_valid(ov3), .samp_out_ready(1'b1), .sync_err(s3));

  logic       v4 = 0, clr4 = 0, r4, ov4, l4, s4;
  logic [7:0] i4 = '0;
  logic [3:0] o4;
  logic       c4;
  comb_mc #(.SAMP_WIDTH(8), .OUT_WIDTH(4), .CIC_M(1), .NUM_CH(1)) d4 (
    .clk(clk), .reset(rst), .clear(clr4), .samp_inp_data(i4),
    .samp_inp_valid(v4), .samp_inp_first(1'b0), .samp_inp_ready(r4),
    .samp_out_data(o4), .samp_out_chan(c4), .samp_out_last(l4),
    .samp_out_valid(ov4), .samp_out_ready(1'b1), .sync_err(s4));

`ifdef COMB_MC_ROUND_EN
  localparam int EXP_18 = 2;
`else
  localparam int EXP_18 = 1;
`endif

  initial begin
    logic [15:0] vals[14];
    int          e1[4], e2[5];
    logic [15:0] in1[4], in2[5];
    logic [7:0]  in3[2];
    int          e3[2];
    vals = '{16'd100, -16'sd200, 16'd3000, 16'd7, 16'd150, -16'sd50, 16'd3100,
             16'h7fff, 16'd1, 16'd2, 16'd3, 16'd4, -16'sd5, 16'h8000};
    in1 = '{16'd10, 16'd100, 16'd13, 16'd90};   e1 = '{10, 100, 3, -10};
    in2 = '{16'd1, 16'd2, 16'd4, 16'd8, 16'd16}; e2 = '{1, 2, 3, 6, 12};
    in3 = '{8'd127, 8'h80};                      e3 = '{127, 1};

    repeat (2) @(posedge clk);
    #2 rst = 0;
    // reset state
    chk("rst_valid", ov0, 0); chk("rst_data", od0, 0); chk("rst_chan", oc0, 0);
    chk("rst_last", last0, 0); chk("rst_sync", serr0, 0); chk("rst_ready", rdy0, 1);

    // two full frames, no stalls
    for (int i = 0; i < 8; i++) send0(vals[i], (i % 4) == 0);

    // backpressure: downstream stalls 3 cycles while input streams
    fork
      for (int i = 8; i < 14; i++) send0(vals[i], (i % 4) == 0);
      begin
        repeat (2) @(posedge clk);
        #1 ordy0 = 0;
        repeat (3) @(posedge clk);
        #1 ordy0 = 1;
      end
    join
    @(negedge clk); #1;
    chk("bp_stall_cycles", stall_cnt, 3);
    chk("bp_beats_out", out_hs, 14);
    @(posedge clk); #2;

    // frame sync error on the 3rd accept
    clr0 = 1; @(posedge clk); #2 clr0 = 0;
    send0(16'd5, 1); send0(16'd6, 0); send0(16'd7, 1);
    @(negedge clk);
    chk("sync_chan", oc0, 0); chk("sync_pulse", serr0, 1); chk("sync_data", od0, 7);
    @(posedge clk); #2;
    send0(16'd8, 0);
    @(negedge clk);
    chk("sync_next_chan", oc0, 1); chk("sync_pulse_end", serr0, 0);
    chk("sync_next_data", od0, 8);
    @(posedge clk); #2;
    send0(16'd11, 0); send0(16'd12, 0); send0(16'd30, 1);
    @(negedge clk);
    chk("m2_data", od0, 25); chk("m2_chan", oc0, 0); chk("m2_sync", serr0, 0);
    @(posedge clk); #2;

    // clear mid-stream with a simultaneous (dropped) input
    send0(16'd40, 0);
    clr0 = 1; vin0 = 1; din0 = 16'd99;
    @(posedge clk); #2 clr0 = 0; vin0 = 0;
    chk("clr_valid", ov0, 0);
    send0(16'd50, 1);
    @(negedge clk);
    chk("clr_data", od0, 50); chk("clr_chan", oc0, 0);
    @(posedge clk); #2;

    // literal vectors on the small instances
    for (int i = 0; i < 5; i++) begin
      v1 = (i < 4); i1 = (i < 4) ? in1[i] : '0; f1 = (i % 2 == 0);
      v2 = 1;       i2 = in2[i];
      v3 = (i < 2); i3 = (i < 2) ? in3[i] : '0;
      @(posedge clk); #1;
      if (i < 4) begin
        chk("d1_data", $signed(o1), e1[i]); chk("d1_chan", c1, i % 2);
        chk("d1_last", l1, i % 2);          chk("d1_sync", s1, 0);
      end
      chk("d2_data", $signed(o2), e2[i]);
      if (i < 2) chk("d3_data", $signed(o3), e3[i]);
      #1;
    end
    v1 = 0; v2 = 0; v3 = 0;

    // 8 -> 4 bit pruning around a clear
    v4 = 1; i4 = 8'h50;
    @(posedge clk); #1 chk("d4_first", $signed(o4), 5);
    #1 clr4 = 1; i4 = 8'h33;
    @(posedge clk); #1 chk("d4_clr_valid", ov4, 0);
    #1 clr4 = 0; i4 = 8'h18;
    @(posedge clk); #1 chk("d4_prune", $signed(o4), EXP_18);
    chk("d4_valid", ov4, 1);
    #1 v4 = 0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
